mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 datapath selector between four requesters.
- Drives the selector's S1/S0 lines so exactly one source is steered onto the shared bus at a time.
- Each grant is held for a burst, ended by the owner or by a hold-limit timeout that prevents starvation.
- Sits in the datapath control layer, between bus-master request logic and the operand/result selector.

Parameters:
- MAXHOLD, 8, maximum consecutive cycles one grant may be held (legal range 1..255).
- CW, 8, width of the internal hold counter; must satisfy 2**CW > MAXHOLD.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ  input  4  request vector; REQ[i] high means requester i wants the bus.
- DONE  input  4  end of burst; DONE[i] is sampled only while requester i is granted.
- GNT  output  4  one-hot grant, or all zeros when idle.
- S0  output  1  selector bit 0; equals the granted index bit 0.
- S1  output  1  selector bit 1; equals the granted index bit 1.
- BUSY  output  1  high while any grant is active.
- HOLDCNT  output  CW  number of cycles the current grant has been held.

Behaviour:
- Reset (asynchronous, RESET_N low):
  - GNT=0, S1/S0=00, BUSY=0, HOLDCNT=0.
  - State IDLE; round-robin pointer PTR=3, so requester 0 has top priority first.
- All outputs are registered. There are no combinational paths from REQ or DONE to any output.
- States are IDLE and OWN.
- IDLE:
  - If REQ==0, stay in IDLE.
  - Otherwise select the first set REQ bit searching PTR+1, PTR+2, PTR+3, PTR (mod 4).
  - On the next edge: GNT=onehot(sel), {S1,S0}=sel, BUSY=1, HOLDCNT=1, state OWN.
  - Latency is one cycle from REQ asserted to GNT visible.
- OWN, with owner o:
  - End condition: DONE[o]=1, or REQ[o]=0, or HOLDCNT==MAXHOLD.
  - No end condition: GNT and S1/S0 stay unchanged and HOLDCNT increments.
  - End condition, PTR=o, then:
    - If another request is pending (REQ with bit o masked is nonzero), hand over directly on the same edge. Pick the winner by rotating priority from o+1. Load GNT, S1/S0 and HOLDCNT=1 for the new owner. There is no idle bubble.
    - Otherwise go to IDLE: GNT=0, BUSY=0, HOLDCNT=0, and S1/S0 hold the last value so the selector does not glitch.
  - The former owner does not win the handover, because bit o is masked. It may re-win from IDLE only when no other request is pending.
- Timeout: HOLDCNT==MAXHOLD forces release even if REQ[o] and DONE[o] are held. MAXHOLD=1 gives a single-cycle grant per arbitration.
- Simultaneous events:
  - DONE[o] and a timeout in the same cycle are treated as one release.
  - REQ or DONE bits of non-owners are ignored for release decisions.
  - A new request arriving in the same cycle as a release is eligible in that arbitration.
- HOLDCNT never exceeds MAXHOLD and never wraps.
- Invariants: GNT is always one-hot or zero. BUSY equals |GNT. When BUSY=1, {S1,S0} always equals the index of the set GNT bit.
- Reset mid-burst: outputs clear immediately, without waiting for a clock edge, and the pointer returns to 3.

Test Plan:
- Reset then idle: RESET_N low with REQ=4'b1111 gives GNT=0, S=00, BUSY=0. Release reset with REQ=0; outputs stay 0 for 5 cycles.
- Single requester: REQ=4'b0100 gives GNT=0100, S1S0=10 one cycle later, HOLDCNT 1,2,3. DONE[2] pulse gives GNT=0, BUSY=0 the next edge, with S1S0 held at 10.
- Round-robin fairness: REQ=4'b1111 held and DONE pulsed each grant gives the grant sequence 0001, 0010, 0100, 1000, 0001 back-to-back with no idle cycles.
- Timeout with MAXHOLD=8: REQ=4'b0011, no DONE gives owner 0 for exactly 8 cycles (HOLDCNT reaches 8), then GNT=0010, S1S0=01, HOLDCNT=1 on the next edge.
- Requester drops REQ: owner 3 deasserts REQ[3] mid-burst while REQ[1]=1 gives GNT=0010 on the next edge. Confirm DONE[1] asserted before the grant has no effect.
- Asynchronous reset mid-burst: assert RESET_N between clock edges while GNT=1000 gives GNT=0 and BUSY=0 immediately. After release, REQ=4'b1001 grants requester 0 first.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between bus masters and the 4:1 selector arbiter.
interface mux4_rr_arbiter_if #(
    parameter int unsigned CW = 8
);
    logic [3:0]    REQ;
    logic [3:0]    DONE;
    logic [3:0]    GNT;
    logic          S0;
    logic          S1;
    logic          BUSY;
    logic [CW-1:0] HOLDCNT;

    // Requester side drives requests and burst ends, observes the grant.
    modport master (
        output REQ,
        output DONE,
        input  GNT,
        input  S0,
        input  S1,
        input  BUSY,
        input  HOLDCNT
    );

    // Arbiter side.
    modport slave (
        input  REQ,
        input  DONE,
        output GNT,
        output S0,
        output S1,
        output BUSY,
        output HOLDCNT
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering one of four requesters onto a shared 4:1 selector.
// Grants last until DONE, REQ drop, or the MAXHOLD timeout; handover has no idle bubble.
module mux4_rr_arbiter #(
    parameter int unsigned MAXHOLD = 8,
    parameter int unsigned CW      = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    mux4_rr_arbiter_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAXHOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [3:0]    pend_other;
    logic          release_c;

    // First set bit of r searching p+1, p+2, p+3, p (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Release decision for the current owner; non-owner DONE/REQ bits are ignored.
    assign pend_other = bus.REQ & ~(4'b0001 << sel_q);
    assign release_c  = bus.DONE[sel_q] | ~bus.REQ[sel_q] | (hold_q == HOLD_MAX);

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and next-output logic; sel holds on release so the selector stays put.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    sel_d   = rr_pick(bus.REQ, ptr_q);
                    gnt_d   = 4'b0001 << sel_d;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_ONE;
                    state_d = OWN;
                end
            end
            OWN: begin
                if (!release_c) begin
                    hold_d = hold_q + HOLD_ONE;
                end else begin
                    ptr_d = sel_q;
                    if (|pend_other) begin
                        sel_d  = rr_pick(pend_other, sel_q);
                        gnt_d  = 4'b0001 << sel_d;
                        hold_d = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.GNT     = gnt_q;
    assign bus.S0      = sel_q[0];
    assign bus.S1      = sel_q[1];
    assign bus.BUSY    = busy_q;
    assign bus.HOLDCNT = hold_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: behavioural owner/pointer model checked every negedge,
// plus directed vectors with literal expectations.
module tb_mux4_rr_arbiter;

    localparam int unsigned MAXHOLD = 8;
    localparam int unsigned CW      = 8;

    logic CLK = 1'b0;
    logic RESET_N;

    always #5 CLK = ~CLK;

    mux4_rr_arbiter_if #(.CW(CW)) bus ();

    mux4_rr_arbiter #(
        .MAXHOLD(MAXHOLD),
        .CW     (CW)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Model: owner index (-1 = idle), priority pointer, hold count, last selector value.
    int m_owner = -1;
    int m_ptr   = 3;
    int m_hold  = 0;
    int m_sel   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] r, input int start, input int excl);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (start + k) % 4;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    function automatic int model_gnt();
        return (m_owner < 0) ? 0 : (1 << m_owner);
    endfunction

    // Model update on each clock edge or asynchronous reset.
    initial begin
        int w;
        bit rel;
        forever begin
            @(posedge CLK or negedge RESET_N);
            if (!RESET_N) begin
                m_owner = -1;
                m_ptr   = 3;
                m_hold  = 0;
                m_sel   = 0;
            end else if (m_owner < 0) begin
                w = winner(bus.REQ, m_ptr, -1);
                if (w >= 0) begin
                    m_owner = w;
                    m_sel   = w;
                    m_hold  = 1;
                end
            end else begin
                rel = bus.DONE[m_owner] || !bus.REQ[m_owner] || (m_hold == int'(MAXHOLD));
                if (!rel) begin
                    m_hold = m_hold + 1;
                end else begin
                    m_ptr = m_owner;
                    w = winner(bus.REQ, m_owner, m_owner);
                    if (w >= 0) begin
                        m_owner = w;
                        m_sel   = w;
                        m_hold  = 1;
                    end else begin
                        m_owner = -1;
                        m_hold  = 0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge CLK);
            chk("cyc_gnt",     int'(bus.GNT), model_gnt());
            chk("cyc_sel",     int'({bus.S1, bus.S0}), m_sel);
            chk("cyc_busy",    int'(bus.BUSY), (m_owner >= 0) ? 1 : 0);
            chk("cyc_holdcnt", int'(bus.HOLDCNT), m_hold);
            chk("cyc_onehot0", int'($onehot0(bus.GNT)), 1);
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic expect_out(input string n, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input int h);
        chk({n, " gnt"},       int'(bus.GNT), int'(g));
        chk({n, " sel"},       int'({bus.S1, bus.S0}), int'(s));
        chk({n, " busy"},      int'(bus.BUSY), int'(b));
        chk({n, " holdcnt"},   int'(bus.HOLDCNT), h);
        chk({n, " model_gnt"}, model_gnt(), int'(g));
    endtask

    task automatic reset_pulse(input string n);
        RESET_N = 1'b0;
        #1;
        expect_out(n, 4'b0000, 2'b00, 1'b0, 0);
        step();
        RESET_N = 1'b1;
    endtask

    // Directed stimulus.
    initial begin
        RESET_N  = 1'b0;
        bus.REQ  = 4'b1111;
        bus.DONE = 4'b0000;
        #13;
        expect_out("reset", 4'b0000, 2'b00, 1'b0, 0);
        step();
        RESET_N = 1'b1;
        bus.REQ = 4'b0000;
        repeat (5) begin
            step();
            expect_out("idle", 4'b0000, 2'b00, 1'b0, 0);
        end

        // Single requester, then DONE release with selector held.
        bus.REQ = 4'b0100;
        step(); expect_out("single1", 4'b0100, 2'b10, 1'b1, 1);
        step(); expect_out("single2", 4'b0100, 2'b10, 1'b1, 2);
        step(); expect_out("single3", 4'b0100, 2'b10, 1'b1, 3);
        bus.DONE = 4'b0100;
        step(); expect_out("single_done", 4'b0000, 2'b10, 1'b0, 0);
        bus.DONE = 4'b0000;
        bus.REQ  = 4'b0000;
        step(); expect_out("single_idle", 4'b0000, 2'b10, 1'b0, 0);

        // Round-robin with DONE held: single-cycle grants back-to-back.
        reset_pulse("rst_rr");
        bus.REQ  = 4'b1111;
        bus.DONE = 4'b1111;
        step(); expect_out("rr0", 4'b0001, 2'b00, 1'b1, 1);
        step(); expect_out("rr1", 4'b0010, 2'b01, 1'b1, 1);
        step(); expect_out("rr2", 4'b0100, 2'b10, 1'b1, 1);
        step(); expect_out("rr3", 4'b1000, 2'b11, 1'b1, 1);
        step(); expect_out("rr4", 4'b0001, 2'b00, 1'b1, 1);
        bus.REQ  = 4'b0000;
        bus.DONE = 4'b0000;
        step(); expect_out("rr_idle", 4'b0000, 2'b00, 1'b0, 0);

        // Hold-limit timeout.
        reset_pulse("rst_to");
        bus.REQ = 4'b0011;
        for (int h = 1; h <= 8; h++) begin
            step();
            expect_out("timeout_hold", 4'b0001, 2'b00, 1'b1, h);
        end
        step(); expect_out("timeout_hand", 4'b0010, 2'b01, 1'b1, 1);

        // REQ drop handovers; non-owner DONE ignored.
        bus.REQ = 4'b1000;
        step(); expect_out("drop1_hand3", 4'b1000, 2'b11, 1'b1, 1);
        bus.REQ  = 4'b1010;
        bus.DONE = 4'b0010;
        step(); expect_out("done_nonowner", 4'b1000, 2'b11, 1'b1, 2);
        bus.REQ  = 4'b0010;
        bus.DONE = 4'b0000;
        step(); expect_out("drop3_hand1", 4'b0010, 2'b01, 1'b1, 1);
        step(); expect_out("after_drop", 4'b0010, 2'b01, 1'b1, 2);

        // Asynchronous reset between edges while requester 3 owns the bus.
        bus.REQ = 4'b1000;
        step(); expect_out("pre_async", 4'b1000, 2'b11, 1'b1, 1);
        #1;
        RESET_N = 1'b0;
        #1;
        expect_out("async_rst", 4'b0000, 2'b00, 1'b0, 0);
        step();
        RESET_N = 1'b1;
        bus.REQ = 4'b1001;
        step(); expect_out("post_async", 4'b0001, 2'b00, 1'b1, 1);
        bus.REQ = 4'b0000;
        step(); expect_out("final_idle", 4'b0000, 2'b00, 1'b0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
